// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state and owner encodings.
package ysyx_22050710_arb_defs;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// Bus bundle of the SRAM arbiter: inst requester, data requester and memory
// port. Signal names are seen from the arbiter (i_* into it, o_* out of it).
// slave modport: the arbiter itself; master modport: its environment.
interface ysyx_22050710_sram_arbiter_if #(
  parameter int SRAM_ADDR_WD = 64,
  parameter int SRAM_DATA_WD = 64,
  parameter int SRAM_MASK_WD = 8
);
  logic                    i_inst_req;
  logic [SRAM_ADDR_WD-1:0] i_inst_addr;
  logic                    o_inst_gnt;
  logic                    o_inst_rvalid;
  logic [SRAM_DATA_WD-1:0] o_inst_rdata;
  logic                    i_data_req;
  logic                    i_data_wen;
  logic [SRAM_ADDR_WD-1:0] i_data_addr;
  logic [SRAM_DATA_WD-1:0] i_data_wdata;
  logic [SRAM_MASK_WD-1:0] i_data_wmask;
  logic                    o_data_gnt;
  logic                    o_data_rvalid;
  logic [SRAM_DATA_WD-1:0] o_data_rdata;
  logic                    o_mem_req;
  logic                    o_mem_wen;
  logic [SRAM_ADDR_WD-1:0] o_mem_addr;
  logic [SRAM_DATA_WD-1:0] o_mem_wdata;
  logic [SRAM_MASK_WD-1:0] o_mem_wmask;
  logic                    i_mem_gnt;
  logic                    i_mem_rvalid;
  logic [SRAM_DATA_WD-1:0] i_mem_rdata;

  modport slave (
    input  i_inst_req, i_inst_addr,
    output o_inst_gnt, o_inst_rvalid, o_inst_rdata,
    input  i_data_req, i_data_wen, i_data_addr, i_data_wdata, i_data_wmask,
    output o_data_gnt, o_data_rvalid, o_data_rdata,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport master (
    output i_inst_req, i_inst_addr,
    input  o_inst_gnt, o_inst_rvalid, o_inst_rdata,
    output i_data_req, i_data_wen, i_data_addr, i_data_wdata, i_data_wmask,
    input  o_data_gnt, o_data_rvalid, o_data_rdata,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/ysyx_22050710_sram_arbiter_pick.sv
// Winner select for the SRAM arbiter.
// Default: data has fixed priority over inst.
// With YSYX_22050710_ARB_RR_EN defined: round-robin on ties using a
// last_owner flop that updates on every grant (resets to DATA, so inst wins
// the first tie).
module ysyx_22050710_arb_pick
  import ysyx_22050710_arb_defs::*;
(
`ifdef YSYX_22050710_ARB_RR_EN
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_gnt_fire,
`endif
  input  logic       i_inst_req,
  input  logic       i_data_req,
  output logic       o_any_req,
  output arb_owner_e o_winner
);

  assign o_any_req = i_inst_req | i_data_req;

`ifdef YSYX_22050710_ARB_RR_EN
  arb_owner_e r_last_owner;

  // Remember who was granted last so a tie goes to the other requester.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_owner <= OWN_DATA;
    end else if (i_gnt_fire) begin
      r_last_owner <= o_winner;
    end
  end

  // Tie goes to the requester not granted last; a lone request always wins.
  always_comb begin
    o_winner = OWN_INST;
    if (i_inst_req && i_data_req) begin
      o_winner = (r_last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
    end else if (i_data_req) begin
      o_winner = OWN_DATA;
    end else begin
      o_winner = OWN_INST;
    end
  end
`else
  // Data wins whenever it asks; otherwise inst.
  always_comb begin
    o_winner = OWN_INST;
    if (i_data_req) begin
      o_winner = OWN_DATA;
    end else begin
      o_winner = OWN_INST;
    end
  end
`endif

endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-requester SRAM arbiter: inst fetch and load/store share one memory port.
// IDLE grants a winner and buffers its request, REQ presents the buffer to the
// memory until gnt, RESP waits for rvalid and routes it back to the owner.
// Optional macro YSYX_22050710_ARB_RR_EN selects round-robin arbitration.
module ysyx_22050710_sram_arbiter
  import ysyx_22050710_arb_defs::*;
#(
  parameter int SRAM_ADDR_WD = 64,
  parameter int SRAM_DATA_WD = 64,
  parameter int SRAM_MASK_WD = 8
) (
  input logic                         i_clk,
  input logic                         i_rst_n,
  ysyx_22050710_sram_arbiter_if.slave bus
);

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  arb_owner_e              r_owner;
  arb_owner_e              w_winner;
  logic                    w_any_req;
  logic                    w_grant;
  logic                    w_resp_fire;
  logic                    r_buf_wen;
  logic [SRAM_ADDR_WD-1:0] r_buf_addr;
  logic [SRAM_DATA_WD-1:0] r_buf_wdata;
  logic [SRAM_MASK_WD-1:0] r_buf_wmask;

  // Gated by reset so that a held request cannot raise gnt during reset.
  assign w_grant = i_rst_n & (r_state == ARB_IDLE) & w_any_req;

  ysyx_22050710_arb_pick u_pick (
`ifdef YSYX_22050710_ARB_RR_EN
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_gnt_fire (w_grant),
`endif
    .i_inst_req (bus.i_inst_req),
    .i_data_req (bus.i_data_req),
    .o_any_req  (w_any_req),
    .o_winner   (w_winner)
  );

  // Next-state logic and detection of the response that ends a transaction.
  always_comb begin
    w_state_nxt = r_state;
    w_resp_fire = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ARB_REQ;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (bus.i_mem_gnt && bus.i_mem_rvalid) begin
          w_resp_fire = 1'b1;
          w_state_nxt = ARB_IDLE;
        end else if (bus.i_mem_gnt) begin
          w_state_nxt = ARB_RESP;
        end else begin
          w_state_nxt = ARB_REQ;
        end
      end
      ARB_RESP: begin
        if (bus.i_mem_rvalid) begin
          w_resp_fire = 1'b1;
          w_state_nxt = ARB_IDLE;
        end else begin
          w_state_nxt = ARB_RESP;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the winner and its request on the grant; inst is always a read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner     <= OWN_INST;
      r_buf_wen   <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
      r_buf_wmask <= '0;
    end else if (w_grant) begin
      r_owner <= w_winner;
      if (w_winner == OWN_DATA) begin
        r_buf_wen   <= bus.i_data_wen;
        r_buf_addr  <= bus.i_data_addr;
        r_buf_wdata <= bus.i_data_wdata;
        r_buf_wmask <= bus.i_data_wmask;
      end else begin
        r_buf_wen   <= 1'b0;
        r_buf_addr  <= bus.i_inst_addr;
        r_buf_wdata <= '0;
        r_buf_wmask <= '0;
      end
    end
  end

  assign bus.o_inst_gnt    = w_grant & (w_winner == OWN_INST);
  assign bus.o_data_gnt    = w_grant & (w_winner == OWN_DATA);
  assign bus.o_inst_rvalid = w_resp_fire & (r_owner == OWN_INST);
  assign bus.o_data_rvalid = w_resp_fire & (r_owner == OWN_DATA);
  assign bus.o_inst_rdata  = bus.o_inst_rvalid ? bus.i_mem_rdata : '0;
  assign bus.o_data_rdata  = bus.o_data_rvalid ? bus.i_mem_rdata : '0;

  // The memory side only ever sees the buffered request.
  assign bus.o_mem_req   = (r_state == ARB_REQ);
  assign bus.o_mem_wen   = r_buf_wen;
  assign bus.o_mem_addr  = r_buf_addr;
  assign bus.o_mem_wdata = r_buf_wdata;
  assign bus.o_mem_wmask = r_buf_wmask;

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Directed bench for ysyx_22050710_sram_arbiter. Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
// Honours YSYX_22050710_ARB_RR_EN for the arbitration expectations.
module tb_ysyx_22050710_sram_arbiter;

`ifdef YSYX_22050710_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  localparam logic [63:0] INST_TIE_ADDR = 64'h0000_0000_8000_0008;
  localparam logic [63:0] DATA_TIE_ADDR = 64'h0000_0000_8000_1000;
  localparam logic [63:0] INST_RDATA    = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DATA_RDATA    = 64'h5555_6666_7777_8888;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  ysyx_22050710_sram_arbiter_if bus ();

  ysyx_22050710_sram_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_inst_gnt"},    bus.o_inst_gnt,    64'd0);
    check_eq({tag, "_data_gnt"},    bus.o_data_gnt,    64'd0);
    check_eq({tag, "_inst_rvalid"}, bus.o_inst_rvalid, 64'd0);
    check_eq({tag, "_data_rvalid"}, bus.o_data_rvalid, 64'd0);
    check_eq({tag, "_inst_rdata"},  bus.o_inst_rdata,  64'd0);
    check_eq({tag, "_data_rdata"},  bus.o_data_rdata,  64'd0);
    check_eq({tag, "_mem_req"},     bus.o_mem_req,     64'd0);
    check_eq({tag, "_mem_wen"},     bus.o_mem_wen,     64'd0);
    check_eq({tag, "_mem_addr"},    bus.o_mem_addr,    64'd0);
    check_eq({tag, "_mem_wdata"},   bus.o_mem_wdata,   64'd0);
    check_eq({tag, "_mem_wmask"},   bus.o_mem_wmask,   64'd0);
  endtask

  // Checks for a cycle spent in REQ: buffered request visible, no grants.
  task automatic check_req(input string tag, input logic [63:0] addr, input bit wen,
                           input logic [63:0] wdata, input logic [7:0] wmask);
    check_eq({tag, "_mem_req"},   bus.o_mem_req,   64'd1);
    check_eq({tag, "_mem_addr"},  bus.o_mem_addr,  addr);
    check_eq({tag, "_mem_wen"},   bus.o_mem_wen,   {63'd0, wen});
    check_eq({tag, "_mem_wdata"}, bus.o_mem_wdata, wdata);
    check_eq({tag, "_mem_wmask"}, bus.o_mem_wmask, {56'd0, wmask});
    check_eq({tag, "_gnt_busy"},  {bus.o_inst_gnt, bus.o_data_gnt}, 64'd0);
  endtask

  task automatic check_resp(input string tag, input bit own_data, input bit wen,
                            input logic [63:0] rdata);
    check_eq({tag, "_inst_rvalid"}, bus.o_inst_rvalid, {63'd0, !own_data});
    check_eq({tag, "_data_rvalid"}, bus.o_data_rvalid, {63'd0, own_data});
    if (own_data) begin
      check_eq({tag, "_inst_rdata_idle"}, bus.o_inst_rdata, 64'd0);
      if (!wen) check_eq({tag, "_data_rdata"}, bus.o_data_rdata, rdata);
    end else begin
      check_eq({tag, "_data_rdata_idle"}, bus.o_data_rdata, 64'd0);
      check_eq({tag, "_inst_rdata"}, bus.o_inst_rdata, rdata);
    end
  endtask

  // Play the memory for one granted transaction; entered just after the
  // edge into REQ, returns just after the edge back into IDLE.
  task automatic serve(input string tag, input bit own_data, input logic [63:0] addr,
                       input bit wen, input logic [63:0] wdata, input logic [7:0] wmask,
                       input logic [63:0] rdata, input int stall, input bit combined);
    for (int k = 0; k < stall; k++) begin
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = (k == 0);
      bus.i_mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      check_req({tag, "_stall"}, addr, wen, wdata, wmask);
      check_eq({tag, "_stall_rvalid"}, {bus.o_inst_rvalid, bus.o_data_rvalid}, 64'd0);
      @(posedge clk); #1;
    end
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = combined;
    bus.i_mem_rdata  = rdata;
    @(negedge clk);
    check_req({tag, "_hs"}, addr, wen, wdata, wmask);
    if (combined) begin
      check_resp({tag, "_comb"}, own_data, wen, rdata);
    end else begin
      check_eq({tag, "_hs_rvalid"}, {bus.o_inst_rvalid, bus.o_data_rvalid}, 64'd0);
    end
    @(posedge clk); #1;
    bus.i_mem_gnt = 1'b0;
    if (!combined) begin
      bus.i_mem_rvalid = 1'b1;
      @(negedge clk);
      check_eq({tag, "_resp_mem_req"}, bus.o_mem_req, 64'd0);
      check_eq({tag, "_resp_gnt"}, {bus.o_inst_gnt, bus.o_data_gnt}, 64'd0);
      check_resp({tag, "_resp"}, own_data, wen, rdata);
      @(posedge clk); #1;
    end
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 64'd0;
  endtask

  initial begin
    bit first_data;
    bit exp_data;
    n_chk  = 0;
    n_fail = 0;
    bus.i_inst_req   = 1'b1;
    bus.i_inst_addr  = 64'd0;
    bus.i_data_req   = 1'b1;
    bus.i_data_wen   = 1'b0;
    bus.i_data_addr  = 64'd0;
    bus.i_data_wdata = 64'd0;
    bus.i_data_wmask = 8'd0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 64'd0;
    rst_n            = 1'b0;

    // Reset with both requests held: everything must read 0.
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    bus.i_data_req = 1'b0;
    rst_n          = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // Simultaneous inst fetch and data load.
    @(posedge clk); #1;
    first_data       = !RR_MODE;
    bus.i_inst_req   = 1'b1;
    bus.i_inst_addr  = INST_TIE_ADDR;
    bus.i_data_req   = 1'b1;
    bus.i_data_addr  = DATA_TIE_ADDR;
    @(negedge clk);
    check_eq("tie_first_inst_gnt", bus.o_inst_gnt, {63'd0, !first_data});
    check_eq("tie_first_data_gnt", bus.o_data_gnt, {63'd0, first_data});
    @(posedge clk); #1;
    if (first_data) bus.i_data_req = 1'b0; else bus.i_inst_req = 1'b0;
    serve("tie_a", first_data, first_data ? DATA_TIE_ADDR : INST_TIE_ADDR, 1'b0, 64'd0, 8'd0,
          first_data ? DATA_RDATA : INST_RDATA, 0, 1'b0);
    @(negedge clk);
    check_eq("tie_second_inst_gnt", bus.o_inst_gnt, {63'd0, first_data});
    check_eq("tie_second_data_gnt", bus.o_data_gnt, {63'd0, !first_data});
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    bus.i_data_req = 1'b0;
    serve("tie_b", !first_data, first_data ? INST_TIE_ADDR : DATA_TIE_ADDR, 1'b0, 64'd0, 8'd0,
          first_data ? INST_RDATA : DATA_RDATA, 0, 1'b0);

    // Both requests held continuously: fixed priority keeps data, RR alternates.
    bus.i_inst_req = 1'b1;
    bus.i_data_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_data = RR_MODE ? (i % 2 == 1) : 1'b1;
      @(negedge clk);
      check_eq("held_inst_gnt", bus.o_inst_gnt, {63'd0, !exp_data});
      check_eq("held_data_gnt", bus.o_data_gnt, {63'd0, exp_data});
      @(posedge clk); #1;
      serve("held", exp_data, exp_data ? DATA_TIE_ADDR : INST_TIE_ADDR, 1'b0, 64'd0, 8'd0,
            exp_data ? DATA_RDATA : INST_RDATA, 0, 1'b0);
    end
    bus.i_inst_req = 1'b0;
    bus.i_data_req = 1'b0;

    // Single fetch, zero-wait memory.
    bus.i_inst_req  = 1'b1;
    bus.i_inst_addr = 64'h0000_0000_8000_0000;
    @(negedge clk);
    check_eq("fetch_inst_gnt", bus.o_inst_gnt, 64'd1);
    check_eq("fetch_data_gnt", bus.o_data_gnt, 64'd0);
    check_eq("fetch_mem_req0", bus.o_mem_req,  64'd0);
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    serve("fetch", 1'b0, 64'h0000_0000_8000_0000, 1'b0, 64'd0, 8'd0,
          64'h0000_0013_0000_0093, 0, 1'b0);
    @(negedge clk);
    check_eq("fetch_rvalid_once", bus.o_inst_rvalid, 64'd0);

    // Store with a 4-cycle memory stall; request inputs change after grant.
    @(posedge clk); #1;
    bus.i_data_req   = 1'b1;
    bus.i_data_wen   = 1'b1;
    bus.i_data_addr  = 64'h0000_0000_8000_2000;
    bus.i_data_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    bus.i_data_wmask = 8'h0F;
    @(negedge clk);
    check_eq("store_data_gnt", bus.o_data_gnt, 64'd1);
    @(posedge clk); #1;
    bus.i_data_req   = 1'b0;
    bus.i_data_wen   = 1'b0;
    bus.i_data_addr  = 64'd0;
    bus.i_data_wdata = 64'd0;
    bus.i_data_wmask = 8'hFF;
    serve("store", 1'b1, 64'h0000_0000_8000_2000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F,
          64'd0, 4, 1'b0);
    @(negedge clk);
    check_eq("store_ack_once", bus.o_data_rvalid, 64'd0);
    bus.i_data_wmask = 8'h00;

    // Combined gnt+rvalid, then a new grant right away from IDLE.
    @(posedge clk); #1;
    bus.i_inst_req  = 1'b1;
    bus.i_inst_addr = 64'h0000_0000_8000_0010;
    @(negedge clk);
    check_eq("comb_inst_gnt", bus.o_inst_gnt, 64'd1);
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    serve("comb", 1'b0, 64'h0000_0000_8000_0010, 1'b0, 64'd0, 8'd0,
          64'hABCD_0123_4567_89EF, 0, 1'b1);
    bus.i_data_req  = 1'b1;
    bus.i_data_addr = 64'h0000_0000_8000_3000;
    @(negedge clk);
    check_eq("comb_next_data_gnt", bus.o_data_gnt, 64'd1);
    @(posedge clk); #1;
    bus.i_data_req = 1'b0;
    serve("comb_next", 1'b1, 64'h0000_0000_8000_3000, 1'b0, 64'd0, 8'd0,
          64'h0F0F_0F0F_F0F0_F0F0, 0, 1'b0);

    // Unsolicited rvalid in IDLE.
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check_eq("unsol_rvalid", {bus.o_inst_rvalid, bus.o_data_rvalid}, 64'd0);
    check_eq("unsol_inst_rdata", bus.o_inst_rdata, 64'd0);
    check_eq("unsol_data_rdata", bus.o_data_rdata, 64'd0);
    check_eq("unsol_mem_req", bus.o_mem_req, 64'd0);
    @(posedge clk); #1;
    bus.i_mem_rvalid = 1'b0;
    bus.i_inst_req   = 1'b1;
    bus.i_inst_addr  = 64'h0000_0000_8000_0018;
    @(negedge clk);
    check_eq("unsol_then_gnt", bus.o_inst_gnt, 64'd1);
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    serve("unsol_fetch", 1'b0, 64'h0000_0000_8000_0018, 1'b0, 64'd0, 8'd0,
          64'h2222_3333_4444_5555, 0, 1'b0);

    // Reset asserted while in RESP.
    bus.i_inst_req  = 1'b1;
    bus.i_inst_addr = 64'h0000_0000_8000_0020;
    @(negedge clk);
    check_eq("rr_fetch_gnt", bus.o_inst_gnt, 64'd1);
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    bus.i_mem_gnt  = 1'b1;
    @(negedge clk);
    check_eq("rr_fetch_mem_req", bus.o_mem_req, 64'd1);
    @(posedge clk); #1;
    bus.i_mem_gnt  = 1'b0;
    bus.i_inst_req = 1'b1;
    #2;
    rst_n            = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'h7777_7777_7777_7777;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("held_rst");
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    rst_n          = 1'b1;
    @(negedge clk);
    check_eq("late_rvalid", {bus.o_inst_rvalid, bus.o_data_rvalid}, 64'd0);
    check_eq("late_inst_rdata", bus.o_inst_rdata, 64'd0);
    @(posedge clk); #1;
    bus.i_mem_rvalid = 1'b0;
    bus.i_inst_req   = 1'b1;
    bus.i_inst_addr  = 64'h0000_0000_8000_0028;
    @(negedge clk);
    check_eq("after_rst_gnt", bus.o_inst_gnt, 64'd1);
    @(posedge clk); #1;
    bus.i_inst_req = 1'b0;
    serve("after_rst", 1'b0, 64'h0000_0000_8000_0028, 1'b0, 64'd0, 8'd0,
          64'h0000_0013_0000_0093, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
